// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small character FIFO.
// Bit timing comes from a CLK_DIV tick divider and an OVERSAMPLE counter.
// Queued characters are sent back to back with no idle gap between frames.
// Ports:
//   CLOCK_50     - sole clock, rising edge
//   reset        - synchronous, active-high
//   DataIn       - character to queue
//   Pload        - write strobe, one character per high cycle
//   enable       - gates the start of new frames only
//   DataOut      - serial line, idle high
//   charReceived - one-cycle pulse in the final cycle of each frame
//   busy         - a frame is on the line
//   full/empty   - FIFO occupancy flags
//   overflow     - sticky, a write was dropped because the FIFO was full
//   level        - FIFO occupancy
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV    = 301,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               CLOCK_50,
    input  logic                               reset,
    input  logic [DATA_BITS-1:0]               DataIn,
    input  logic                               Pload,
    input  logic                               enable,
    output logic                               DataOut,
    output logic                               charReceived,
    output logic                               busy,
    output logic                               full,
    output logic                               empty,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned TICK_W = $clog2(CLK_DIV);
    localparam int unsigned OS_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [OS_W-1:0]      os_q, os_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 char_q, char_d;
    logic                 busy_q, busy_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_q, ovf_d;
    logic [LVL_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic wr_en;
    logic pop;
    logic can_pop;
    logic tick_wrap;
    logic bit_end;

    // Next-state, FIFO bookkeeping and registered-output values.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        os_d     = os_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop      = 1'b0;

        wr_en     = Pload && !full_q;
        ovf_d     = ovf_q || (Pload && full_q);
        can_pop   = !empty_q && enable;
        tick_wrap = (tick_q == TICK_W'(CLK_DIV - 1));
        bit_end   = tick_wrap && (os_q == OS_W'(OVERSAMPLE - 1));

        // Bit-timing counters run only while a frame is on the line.
        if (state_q != ST_IDLE) begin
            tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
            if (tick_wrap) begin
                os_d = (os_q == OS_W'(OVERSAMPLE - 1)) ? '0 : os_q + OS_W'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                    tick_d  = '0;
                    os_d    = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when data waits.
                        if (can_pop) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                        tick_d = '0;
                        os_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            par_d    = (^mem_q[rd_ptr_q]) ^ (PARITY == 2);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == LVL_W'(FIFO_DEPTH));
        empty_d = (count_d == '0);

        unique case (state_d)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_d[0];
            ST_PARITY: line_d = par_d;
            default:   line_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        // Pulse during the final cycle of the last stop bit.
        char_d = (state_d == ST_STOP) && (bit_d == BIT_W'(STOP_BITS - 1)) &&
                 (tick_d == TICK_W'(CLK_DIV - 1)) && (os_d == OS_W'(OVERSAMPLE - 1));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            os_q     <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            line_q   <= 1'b1;
            char_q   <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            os_q     <= os_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            line_q   <= line_d;
            char_q   <= char_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage; a write coinciding with reset is discarded.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= DataIn;
        end
    end

    assign DataOut      = line_q;
    assign charReceived = char_q;
    assign busy         = busy_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign overflow     = ovf_q;
    assign level        = count_q;

endmodule
